// File: rtl/addsub_pkg.sv
// Shared types and helpers for the add/sub accumulator datapath.
package addsub_pkg;

   typedef enum logic [1:0] {
      OP_ADD     = 2'b00,
      OP_SUB     = 2'b01,
      OP_ACC_ADD = 2'b10,
      OP_ACC_SUB = 2'b11
   } op_e;

   // Returned at 64 bits; callers truncate to their own WIDTH (WIDTH <= 64).
   function automatic logic [63:0] sat_min(input int unsigned w);
      return 64'd1 << (w - 1);
   endfunction

   function automatic logic [63:0] sat_max(input int unsigned w);
      return sat_min(w) - 64'd1;
   endfunction

endpackage

// File: rtl/addsub_core.sv
// Combinational WIDTH-bit adder/subtractor with raw carry and signed overflow.
module addsub_core #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             sub,
   output logic [WIDTH-1:0] raw,
   output logic             co,
   output logic             ofl
);

   logic [WIDTH-1:0] ysel;

   always_comb begin
      ysel      = y ^ {WIDTH{sub}};
      {co, raw} = {1'b0, x} + {1'b0, ysel} + (WIDTH+1)'(sub);
      // Same-sign operands producing an opposite-sign result.
      ofl       = (x[WIDTH-1] == ysel[WIDTH-1]) && (raw[WIDTH-1] != x[WIDTH-1]);
   end

endmodule

// File: rtl/addsub_pipe.sv
// Registered add/sub with accumulator, optional signed saturation and a
// single-register valid/ready stage.
module addsub_pipe
   import addsub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   input  logic             sat,
   input  logic             clr_acc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic             ofl,
   output logic             zero,
   output logic             neg,
   output logic [WIDTH-1:0] acc
);

   localparam logic [WIDTH-1:0] S_MAX = WIDTH'(sat_max(WIDTH));
   localparam logic [WIDTH-1:0] S_MIN = WIDTH'(sat_min(WIDTH));

   op_e              op_w;
   logic             is_acc, sub, accept;
   logic [WIDTH-1:0] acc_eff, x, y, raw, s_sat;
   logic             raw_co, raw_ofl;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] s_q, s_d, acc_q, acc_d;
   logic             co_q, co_d, ofl_q, ofl_d, zero_q, zero_d, neg_q, neg_d;

   assign op_w     = op_e'(op);
   assign is_acc   = (op_w == OP_ACC_ADD) || (op_w == OP_ACC_SUB);
   assign sub      = (op_w == OP_SUB) || (op_w == OP_ACC_SUB);
   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   assign acc_eff  = clr_acc ? '0 : acc_q;
   assign x        = is_acc ? acc_eff : a;
   assign y        = is_acc ? a : b;

   addsub_core #(.WIDTH(WIDTH)) u_core (
      .x   (x),
      .y   (y),
      .sub (sub),
      .raw (raw),
      .co  (raw_co),
      .ofl (raw_ofl)
   );

   // Overflow direction follows the sign of X.
   assign s_sat = (sat && raw_ofl) ? (x[WIDTH-1] ? S_MIN : S_MAX) : raw;

   always_comb begin
      out_valid_d = out_valid_q;
      s_d         = s_q;
      co_d        = co_q;
      ofl_d       = ofl_q;
      zero_d      = zero_q;
      neg_d       = neg_q;
      acc_d       = acc_q;
      if (accept) begin
         out_valid_d = 1'b1;
         s_d         = s_sat;
         co_d        = raw_co;
         ofl_d       = raw_ofl;
         zero_d      = (s_sat == '0);
         neg_d       = s_sat[WIDTH-1];
         if (is_acc)       acc_d = s_sat;
         else if (clr_acc) acc_d = '0;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         s_q         <= '0;
         co_q        <= 1'b0;
         ofl_q       <= 1'b0;
         zero_q      <= 1'b0;
         neg_q       <= 1'b0;
         acc_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         s_q         <= s_d;
         co_q        <= co_d;
         ofl_q       <= ofl_d;
         zero_q      <= zero_d;
         neg_q       <= neg_d;
         acc_q       <= acc_d;
      end
   end

   assign out_valid = out_valid_q;
   assign s         = s_q;
   assign co        = co_q;
   assign ofl       = ofl_q;
   assign zero      = zero_q;
   assign neg       = neg_q;
   assign acc       = acc_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: directed vector table, handshake/reset sequences and
// randomized traffic against an integer-arithmetic reference model.
module tb_addsub_pipe;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0, in_ready;
   logic [W-1:0] a = '0, b = '0;
   logic [1:0]   op = 2'b00;
   logic         sat = 1'b0, clr_acc = 1'b0;
   logic         out_valid, out_ready = 1'b1;
   logic [W-1:0] s, acc;
   logic         co, ofl, zero, neg;

   int n_vec = 0;
   int n_err = 0;
   logic [W-1:0] model_acc = '0;

   always #5 clk = ~clk;

   addsub_pipe #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .sat(sat), .clr_acc(clr_acc),
      .out_valid(out_valid), .out_ready(out_ready),
      .s(s), .co(co), .ofl(ofl), .zero(zero), .neg(neg), .acc(acc)
   );

   typedef struct {
      logic [7:0] a, b;
      logic [1:0] op;
      logic       sat, clr;
      logic [7:0] s;
      logic       co, ofl, zero, neg;
      logic [7:0] acc;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: plain unsigned/signed integer arithmetic on the chosen operands.
   task automatic model(input logic [7:0] ta, tb, input logic [1:0] top,
                        input logic tsat, tclr, input logic [7:0] acc_in,
                        output logic [7:0] ms, output logic mco, mofl, mzero, mneg,
                        output logic [7:0] macc);
      int x, y, sx, sy, su, ss, res;
      x  = top[1] ? (tclr ? 0 : int'(acc_in)) : int'(ta);
      y  = top[1] ? int'(ta) : int'(tb);
      sx = (x >= 128) ? x - 256 : x;
      sy = (y >= 128) ? y - 256 : y;
      if (top[0]) begin
         su = x - y;  ss = sx - sy;  mco = (x >= y);
      end else begin
         su = x + y;  ss = sx + sy;  mco = (su >= 256);
      end
      mofl = (ss > 127) || (ss < -128);
      if (tsat && mofl) res = (ss > 127) ? 127 : -128;
      else              res = su;
      ms    = res[7:0];
      mzero = (ms == 8'h00);
      mneg  = ms[7];
      macc  = top[1] ? ms : (tclr ? 8'h00 : acc_in);
   endtask

   // One accepted beat with out_ready held high; returns after the capturing edge.
   task automatic send(input logic [7:0] ta, tb, input logic [1:0] top,
                       input logic tsat, tclr);
      logic [7:0] ms, macc;
      logic       mco, mofl, mz, mn;
      a = ta; b = tb; op = top; sat = tsat; clr_acc = tclr;
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      model(ta, tb, top, tsat, tclr, model_acc, ms, mco, mofl, mz, mn, macc);
      model_acc = macc;
   endtask

   vec_t tbl[13];

   logic [7:0] e_s, e_acc, m_s, m_acc;
   logic       e_valid, e_co, e_ofl, e_z, e_n, m_co, m_ofl, m_z, m_n, acc_now;

   initial begin
      tbl[0]  = '{8'hF6, 8'h0A, 2'b00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
      tbl[1]  = '{8'h7F, 8'h01, 2'b00, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00};
      tbl[2]  = '{8'h7F, 8'h01, 2'b00, 1'b1, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
      tbl[3]  = '{8'h05, 8'h0A, 2'b01, 1'b0, 1'b0, 8'hFB, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
      tbl[4]  = '{8'h80, 8'h01, 2'b01, 1'b1, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00};
      tbl[5]  = '{8'h03, 8'h55, 2'b10, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 8'h03};
      tbl[6]  = '{8'h04, 8'h55, 2'b10, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0, 8'h07};
      tbl[7]  = '{8'h05, 8'h55, 2'b10, 1'b0, 1'b0, 8'h0C, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0C};
      tbl[8]  = '{8'h14, 8'h55, 2'b11, 1'b0, 1'b0, 8'hF8, 1'b0, 1'b0, 1'b0, 1'b1, 8'hF8};
      tbl[9]  = '{8'h01, 8'h02, 2'b00, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[10] = '{8'h70, 8'h00, 2'b10, 1'b1, 1'b0, 8'h70, 1'b0, 1'b0, 1'b0, 1'b0, 8'h70};
      tbl[11] = '{8'h20, 8'h00, 2'b10, 1'b1, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0, 8'h7F};
      tbl[12] = '{8'h01, 8'h00, 2'b11, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF};

      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_s",         32'(s),         32'd0);
      chk("rst_flags",     {28'd0, co, ofl, zero, neg}, 32'd0);
      chk("rst_acc",       32'(acc),       32'd0);
      #11 rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 13; i++) begin
         send(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].sat, tbl[i].clr);
         chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("v%0d_s", i),     32'(s),         32'(tbl[i].s));
         chk($sformatf("v%0d_co", i),    32'(co),        32'(tbl[i].co));
         chk($sformatf("v%0d_ofl", i),   32'(ofl),       32'(tbl[i].ofl));
         chk($sformatf("v%0d_zero", i),  32'(zero),      32'(tbl[i].zero));
         chk($sformatf("v%0d_neg", i),   32'(neg),       32'(tbl[i].neg));
         chk($sformatf("v%0d_acc", i),   32'(acc),       32'(tbl[i].acc));
      end

      // Backpressure: result held, input stalled, accumulator untouched.
      send(8'h01, 8'h02, 2'b00, 1'b0, 1'b0);
      out_ready = 1'b0;
      a = 8'h0A; b = 8'h14; op = 2'b00; in_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         @(posedge clk); #1;
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_s",     32'(s),         32'h03);
         chk("bp_acc",   32'(acc),       32'(model_acc));
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_next_valid", 32'(out_valid), 32'd1);
      chk("bp_next_s",     32'(s),         32'h1E);
      @(posedge clk); #1;
      chk("drain_valid", 32'(out_valid), 32'd0);

      // Randomized traffic with random stalls on both sides.
      e_valid = 1'b0;
      e_s = s; e_co = co; e_ofl = ofl; e_z = zero; e_n = neg;
      for (int i = 0; i < 400; i++) begin
         a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
         sat = 1'($urandom); clr_acc = ($urandom_range(0, 7) == 0);
         in_valid = 1'($urandom); out_ready = ($urandom_range(0, 3) != 0);
         #1;
         chk("rnd_in_ready", 32'(in_ready), 32'(!e_valid || out_ready));
         acc_now = in_valid && (!e_valid || out_ready);
         model(a, b, op, sat, clr_acc, model_acc, m_s, m_co, m_ofl, m_z, m_n, m_acc);
         @(posedge clk); #1;
         if (acc_now) begin
            e_valid = 1'b1; e_s = m_s; e_co = m_co; e_ofl = m_ofl; e_z = m_z; e_n = m_n;
            model_acc = m_acc;
         end else if (out_ready) begin
            e_valid = 1'b0;
         end
         chk("rnd_valid", 32'(out_valid), 32'(e_valid));
         chk("rnd_acc",   32'(acc),       32'(model_acc));
         if (e_valid) begin
            chk("rnd_s",     32'(s), 32'(e_s));
            chk("rnd_flags", {28'd0, co, ofl, zero, neg}, {28'd0, e_co, e_ofl, e_z, e_n});
         end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;

      // Asynchronous reset while a result is pending.
      send(8'h0C, 8'h00, 2'b10, 1'b0, 1'b1);
      chk("pre_rst_acc",   32'(acc),       32'h0C);
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_s",     32'(s),         32'd0);
      chk("mid_rst_acc",   32'(acc),       32'd0);
      #2 rst_n = 1'b1;
      model_acc = '0;
      @(posedge clk); #1;
      send(8'hF6, 8'h0A, 2'b00, 1'b0, 1'b0);
      chk("post_rst_s",    32'(s),    32'h00);
      chk("post_rst_co",   32'(co),   32'd1);
      chk("post_rst_zero", 32'(zero), 32'd1);
      send(8'h05, 8'h00, 2'b10, 1'b0, 1'b0);
      chk("post_rst_acc",  32'(acc),  32'h05);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
